// File: rtl/rv_rr_grant_stage_if.sv
// Grant handshake bundle between the round-robin stage and its consumer.
// The stage takes the master side: it drives the grant and samples requests/ready.
interface rv_rr_grant_stage_if #(
  parameter int N  = 8,
  parameter int LN = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]  requests;
  logic          grant_valid;
  logic          grant_ready;
  logic [N-1:0]  grant_onehot;
  logic [LN-1:0] grant_index;
  logic [N-1:0]  req_ack;

  modport master (
    input  requests, grant_ready,
    output grant_valid, grant_onehot, grant_index, req_ack
  );

  modport slave (
    output requests, grant_ready,
    input  grant_valid, grant_onehot, grant_index, req_ack
  );
endinterface

// File: rtl/rv_rr_grant_stage.sv
// Round-robin grant stage: rotating-priority pick over a request vector,
// winner registered behind a valid/ready handshake.

// Lowest set bit wins; reports one-hot, binary index and whether any bit is set.
module RV_priority_encoder #(
  parameter int N  = 8,
  parameter int LN = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  output logic          o_any,
  output logic [N-1:0]  o_onehot,
  output logic [LN-1:0] o_index
);
  assign o_any    = |i_req;
  assign o_onehot = i_req & (~i_req + N'(1));

  always_comb begin
    o_index = '0;
    for (int i = N - 1; i >= 0; i--)
      if (i_req[i]) o_index = LN'(i);
  end
endmodule

module rv_rr_grant_stage #(
  parameter int N  = 8,
  parameter int LN = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  rv_rr_grant_stage_if.master  bus
);
  logic [LN-1:0] r_ptr;
  logic [LN-1:0] r_index;
  logic [N-1:0]  r_onehot;
  logic          r_valid;

  logic [N-1:0]  w_hi_mask;
  logic [N-1:0]  w_masked;
  logic          w_hi_any, w_all_any;
  logic [N-1:0]  w_hi_oh, w_all_oh, w_win_oh;
  logic [LN-1:0] w_hi_idx, w_all_idx, w_win_idx;
  logic          w_fire, w_load;

  // Only requesters strictly after the last winner compete first; ptr=N-1 opens the whole vector.
  for (genvar i = 0; i < N; i++) begin : g_mask
    assign w_hi_mask[i] = (LN'(i) > r_ptr);
  end

  assign w_masked = bus.requests & w_hi_mask;

  RV_priority_encoder #(.N(N), .LN(LN)) u_enc_hi (
    .i_req    (w_masked),
    .o_any    (w_hi_any),
    .o_onehot (w_hi_oh),
    .o_index  (w_hi_idx)
  );

  RV_priority_encoder #(.N(N), .LN(LN)) u_enc_all (
    .i_req    (bus.requests),
    .o_any    (w_all_any),
    .o_onehot (w_all_oh),
    .o_index  (w_all_idx)
  );

  assign w_win_oh  = w_hi_any ? w_hi_oh  : w_all_oh;
  assign w_win_idx = w_hi_any ? w_hi_idx : w_all_idx;

  assign w_fire = r_valid & bus.grant_ready;
  assign w_load = ~r_valid | bus.grant_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_onehot <= '0;
      r_index  <= '0;
      r_ptr    <= LN'(N - 1);
    end else if (w_load) begin
      if (w_all_any) begin
        r_valid  <= 1'b1;
        r_onehot <= w_win_oh;
        r_index  <= w_win_idx;
        r_ptr    <= w_win_idx;
      end else begin
        // Idle: outputs clear but ptr keeps its place in the rotation.
        r_valid  <= 1'b0;
        r_onehot <= '0;
        r_index  <= '0;
      end
    end
  end

  assign bus.grant_valid  = r_valid;
  assign bus.grant_onehot = r_onehot;
  assign bus.grant_index  = r_index;
  assign bus.req_ack      = r_onehot & {N{w_fire}};
endmodule

// File: tb/tb_rv_rr_grant_stage.sv
// Bench for rv_rr_grant_stage: directed scenarios on N=4 plus rotation and
// randomized sticky-request traffic on N=4, N=5 and N=2 builds.
module tb_rv_rr_grant_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  rv_rr_grant_stage_if #(.N(4)) if4 ();
  rv_rr_grant_stage_if #(.N(5)) if5 ();
  rv_rr_grant_stage_if #(.N(2)) if2 ();

  rv_rr_grant_stage #(.N(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  rv_rr_grant_stage #(.N(5)) dut5 (.clk(clk), .reset(reset), .bus(if5));
  rv_rr_grant_stage #(.N(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  logic [7:0] drv_req [3];
  logic       drv_rdy [3];
  logic [7:0] ob_oh  [3];
  logic [7:0] ob_ack [3];
  logic       ob_v   [3];
  logic [2:0] ob_idx [3];
  int nn [3] = '{4, 5, 2};

  assign if4.requests = drv_req[0][3:0];
  assign if5.requests = drv_req[1][4:0];
  assign if2.requests = drv_req[2][1:0];
  assign if4.grant_ready = drv_rdy[0];
  assign if5.grant_ready = drv_rdy[1];
  assign if2.grant_ready = drv_rdy[2];

  assign ob_v[0] = if4.grant_valid;
  assign ob_v[1] = if5.grant_valid;
  assign ob_v[2] = if2.grant_valid;
  assign ob_oh[0] = {4'b0, if4.grant_onehot};
  assign ob_oh[1] = {3'b0, if5.grant_onehot};
  assign ob_oh[2] = {6'b0, if2.grant_onehot};
  assign ob_ack[0] = {4'b0, if4.req_ack};
  assign ob_ack[1] = {3'b0, if5.req_ack};
  assign ob_ack[2] = {6'b0, if2.req_ack};
  assign ob_idx[0] = {1'b0, if4.grant_index};
  assign ob_idx[1] = if5.grant_index;
  assign ob_idx[2] = {2'b0, if2.grant_index};

  // Reference: scan requesters in rotation order starting just after the last winner.
  function automatic int rr_winner(int n, int ptr, logic [7:0] req);
    for (int k = 1; k <= n; k++) begin
      int j;
      j = (ptr + k) % n;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      drv_req[d] = '0;
      drv_rdy[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      drv_req[d] = 8'hff;
      drv_rdy[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (ob_v[d] !== 1'b0 || ob_oh[d] !== 8'h0 || ob_idx[d] !== 3'd0 || ob_ack[d] !== 8'h0) begin
        fails++;
        $display("FAIL reset d=%0d got v=%b oh=%h idx=%0d ack=%h required all zero",
                 d, ob_v[d], ob_oh[d], ob_idx[d], ob_ack[d]);
      end
    end
    do_reset();
  endtask

  task automatic test_rotation();
    do_reset();
    for (int d = 0; d < 3; d++) begin
      drv_req[d] = 8'((1 << nn[d]) - 1);
      drv_rdy[d] = 1'b1;
    end
    for (int c = 0; c < 10; c++) begin
      step();
      for (int d = 0; d < 3; d++) begin
        int e;
        e = c % nn[d];
        tests++;
        if (ob_v[d] !== 1'b1 || ob_idx[d] !== 3'(e) || ob_ack[d] !== 8'(1 << e)) begin
          fails++;
          $display("FAIL rotation d=%0d cyc=%0d got v=%b idx=%0d ack=%h required v=1 idx=%0d ack=%h",
                   d, c, ob_v[d], ob_idx[d], ob_ack[d], e, 8'(1 << e));
        end
      end
    end
  endtask

  task automatic test_wrap();
    int seq [6] = '{0, 1, 2, 0, 1, 0};
    do_reset();
    drv_req[0] = 8'b1111;
    drv_rdy[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 2) drv_req[0] = 8'b0011;
      tests++;
      if (ob_v[0] !== 1'b1 || ob_idx[0] !== 3'(seq[c])) begin
        fails++;
        $display("FAIL wrap cyc=%0d got v=%b idx=%0d required v=1 idx=%0d", c, ob_v[0], ob_idx[0], seq[c]);
      end
    end
  endtask

  task automatic test_stall_idle();
    do_reset();
    drv_req[0] = 8'b0010;
    drv_rdy[0] = 1'b0;
    step();
    for (int c = 0; c < 6; c++) begin
      tests++;
      if (ob_v[0] !== 1'b1 || ob_oh[0] !== 8'b0010 || ob_idx[0] !== 3'd1 || ob_ack[0] !== 8'h0) begin
        fails++;
        $display("FAIL stall cyc=%0d got v=%b oh=%h idx=%0d ack=%h required v=1 oh=02 idx=1 ack=00",
                 c, ob_v[0], ob_oh[0], ob_idx[0], ob_ack[0]);
      end
      drv_req[0] = 8'($urandom);
      if (c < 5) step();
    end
    drv_rdy[0] = 1'b1;
    drv_req[0] = 8'h0;
    #1;
    tests++;
    if (ob_ack[0] !== 8'b0010) begin
      fails++;
      $display("FAIL release_ack got=%h required=02", ob_ack[0]);
    end
    step();
    tests++;
    if (ob_v[0] !== 1'b0 || ob_oh[0] !== 8'h0 || ob_idx[0] !== 3'd0 || ob_ack[0] !== 8'h0) begin
      fails++;
      $display("FAIL idle got v=%b oh=%h idx=%0d ack=%h required all zero", ob_v[0], ob_oh[0], ob_idx[0], ob_ack[0]);
    end
    drv_req[0] = 8'b1000;
    step();
    tests++;
    if (ob_v[0] !== 1'b1 || ob_idx[0] !== 3'd3 || ob_oh[0] !== 8'b1000) begin
      fails++;
      $display("FAIL after_idle got v=%b idx=%0d oh=%h required v=1 idx=3 oh=08", ob_v[0], ob_idx[0], ob_oh[0]);
    end
  endtask

  task automatic test_async_reset();
    drv_rdy[0] = 1'b0;
    drv_req[0] = 8'b1000;
    step();
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (ob_v[0] !== 1'b0 || ob_oh[0] !== 8'h0 || ob_idx[0] !== 3'd0 || ob_ack[0] !== 8'h0) begin
      fails++;
      $display("FAIL async_reset got v=%b oh=%h idx=%0d ack=%h required all zero", ob_v[0], ob_oh[0], ob_idx[0], ob_ack[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    drv_req[0] = 8'b0110;
    drv_rdy[0] = 1'b1;
    step();
    tests++;
    if (ob_v[0] !== 1'b1 || ob_idx[0] !== 3'd1) begin
      fails++;
      $display("FAIL post_reset got v=%b idx=%0d required v=1 idx=1", ob_v[0], ob_idx[0]);
    end
  endtask

  task automatic test_random(int cycles);
    int m_v [3];
    int m_idx [3];
    int m_ptr [3];
    int pend [3][8];
    logic [7:0] last_ack [3];
    do_reset();
    for (int d = 0; d < 3; d++) begin
      m_v[d] = 0; m_idx[d] = 0; m_ptr[d] = nn[d] - 1; last_ack[d] = '0;
      for (int i = 0; i < 8; i++) pend[d][i] = 0;
    end
    step();
    for (int c = 0; c < cycles; c++) begin
      for (int d = 0; d < 3; d++) begin
        logic [7:0] eoh;
        eoh = m_v[d] ? 8'(1 << m_idx[d]) : 8'h0;
        tests++;
        if (ob_v[d] !== (m_v[d] != 0) || ob_oh[d] !== eoh || ob_idx[d] !== 3'(m_idx[d])) begin
          fails++;
          $display("FAIL rand_grant d=%0d cyc=%0d got v=%b oh=%h idx=%0d required v=%0d oh=%h idx=%0d",
                   d, c, ob_v[d], ob_oh[d], ob_idx[d], m_v[d], eoh, m_idx[d]);
        end
        drv_req[d] = ((drv_req[d] & ~last_ack[d]) | 8'($urandom & $urandom & $urandom)) & 8'((1 << nn[d]) - 1);
        drv_rdy[d] = ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        logic [7:0] eack;
        int w;
        eack = (m_v[d] != 0 && drv_rdy[d]) ? 8'(1 << m_idx[d]) : 8'h0;
        tests++;
        if (ob_ack[d] !== eack) begin
          fails++;
          $display("FAIL rand_ack d=%0d cyc=%0d got=%h required=%h", d, c, ob_ack[d], eack);
        end
        for (int i = 0; i < nn[d]; i++) begin
          if (!drv_req[d][i] || eack[i]) pend[d][i] = 0;
          else if (eack != 0) pend[d][i]++;
          if (pend[d][i] > nn[d]) begin
            tests++;
            fails++;
            $display("FAIL starve d=%0d req=%0d got %0d fires waiting required at most %0d", d, i, pend[d][i], nn[d]);
            pend[d][i] = 0;
          end
        end
        last_ack[d] = eack;
        if (m_v[d] == 0 || drv_rdy[d]) begin
          w = rr_winner(nn[d], m_ptr[d], drv_req[d]);
          if (w >= 0) begin
            m_v[d] = 1; m_idx[d] = w; m_ptr[d] = w;
          end else begin
            m_v[d] = 0; m_idx[d] = 0;
          end
        end
      end
      step();
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      drv_req[d] = '0;
      drv_rdy[d] = 1'b0;
    end
    test_reset();
    test_rotation();
    test_wrap();
    test_stall_idle();
    test_async_reset();
    test_random(10000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
